// File: rtl/floor_request_panel_if.sv
// Controller-facing link of the floor request panel.
// The panel takes the slave modport and the elevator controller takes the master modport.
interface floor_request_panel_if;
   logic [2:0] current_floor;
   logic [7:0] requests_in;
   logic       emergency;
   logic [2:0] req_floor;
   logic       req_valid;

   modport master (
      output current_floor, requests_in, emergency,
      input  req_floor, req_valid
   );

   modport slave (
      input  current_floor, requests_in, emergency,
      output req_floor, req_valid
   );
endinterface

// File: rtl/floor_request_panel.sv
// Floor request panel: debounces buttons, lights lamps, queues floors and issues them one at a time.
// Optional PANEL_EMERGENCY_FLUSH_EN: emergency flushes queue and lamps and blocks presses.
//
// state | meaning
// IDLE  | no request on the bus; pops the FIFO head when non-empty and emergency is low
// HOLD  | req_floor/req_valid held for HOLD_CYCLES cycles
module floor_request_panel #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES     = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [7:0]                 buttons,
   floor_request_panel_if.slave       bus,
   output logic [7:0]                 lamps,
   output logic [3:0]                 pending_count
);

   localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

   typedef enum logic {IDLE, HOLD} state_t;

   logic [7:0]      sync_a, sync_b;
   logic [7:0][3:0] deb_cnt;
   logic [7:0]      fired;
   logic [7:0]      press, accept, cur_mask, served;
   logic [7:0]      req_q;
   logic [7:0]      pend_vec, pend_low;
   logic [2:0]      pend_floor;
   logic            push, pop, flush, fifo_empty;
   logic [2:0]      fifo_mem [8];
   logic [2:0]      wr_ptr, rd_ptr;
   logic [3:0]      count;
   state_t          state, state_nxt;
   logic [3:0]      hold_cnt, hold_cnt_nxt;
   logic [2:0]      req_floor_q;

`ifdef PANEL_EMERGENCY_FLUSH_EN
   assign flush = bus.emergency;
`else
   assign flush = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= buttons;
         sync_b <= sync_a;
      end
   end

   // A press fires once per high level; the fired flag re-arms only when the level drops.
   always_comb begin
      press = '0;
      for (int f = 0; f < 8; f++)
         press[f] = sync_b[f] && !fired[f] && (deb_cnt[f] == DEB_LAST);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         deb_cnt <= '0;
         fired   <= '0;
      end else begin
         for (int f = 0; f < 8; f++) begin
            if (!sync_b[f]) begin
               deb_cnt[f] <= '0;
               fired[f]   <= 1'b0;
            end else if (!fired[f]) begin
               if (deb_cnt[f] == DEB_LAST) fired[f] <= 1'b1;
               else                        deb_cnt[f] <= deb_cnt[f] + 4'd1;
            end
         end
      end
   end

   assign cur_mask = 8'd1 << bus.current_floor;
   assign accept   = press & ~lamps & ~cur_mask & {8{~flush}};
   assign served   = req_q & ~bus.requests_in;
   assign pend_low = pend_vec & (~pend_vec + 8'd1);
   assign push     = (|pend_vec) && !flush;

   always_comb begin
      pend_floor = '0;
      for (int i = 7; i >= 0; i--)
         if (pend_vec[i]) pend_floor = 3'(i);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lamps    <= '0;
         pend_vec <= '0;
         req_q    <= '0;
      end else begin
         req_q <= bus.requests_in;
         if (flush) begin
            lamps    <= '0;
            pend_vec <= '0;
         end else begin
            lamps    <= (lamps & ~served) | accept;
            pend_vec <= (pend_vec & ~pend_low) | accept;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= pend_floor;
   end

   assign fifo_empty    = (count == 4'd0);
   assign pending_count = count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 3'd1;
         if (pop)  rd_ptr <= rd_ptr + 3'd1;
         case ({push, pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      pop          = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty && !bus.emergency) begin
               pop          = 1'b1;
               state_nxt    = HOLD;
               hold_cnt_nxt = HOLD_LAST;
            end
         end
         HOLD: begin
            if (hold_cnt == 4'd0) state_nxt    = IDLE;
            else                  hold_cnt_nxt = hold_cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         req_floor_q <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
         if (pop) req_floor_q <= fifo_mem[rd_ptr];
      end
   end

   // req_valid follows the state register so an async reset drops it immediately.
   assign bus.req_valid = (state == HOLD);
   assign bus.req_floor = req_floor_q;

endmodule

// File: tb/tb_floor_request_panel.sv
// Directed bench for floor_request_panel with default parameters.
// Honours PANEL_EMERGENCY_FLUSH_EN for the emergency scenario.
module tb_floor_request_panel;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] buttons = '0;
   logic [7:0] lamps;
   logic [3:0] pending_count;

   floor_request_panel_if bus ();

   floor_request_panel dut (
      .clock         (clock),
      .reset         (reset),
      .buttons       (buttons),
      .bus           (bus.slave),
      .lamps         (lamps),
      .pending_count (pending_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [2:0] issued [$];
   int         widths [$];
   int         width = 0;
   int         unstable = 0;
   int         peak = 0;
   logic       prev_v = 1'b0;
   logic [2:0] last_f = '0;

   // Observer: records each issued floor, pulse width and floor stability.
   always @(negedge clock) begin
      if (!reset) begin
         prev_v = 1'b0;
         width  = 0;
      end else begin
         if (bus.req_valid) begin
            if (!prev_v) begin
               issued.push_back(bus.req_floor);
               last_f = bus.req_floor;
               width  = 1;
            end else begin
               width++;
               if (bus.req_floor !== last_f) unstable++;
            end
         end else if (prev_v) begin
            widths.push_back(width);
         end
         if (int'(pending_count) > peak) peak = int'(pending_count);
         prev_v = bus.req_valid;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic serve(input logic [7:0] mask);
      bus.requests_in = mask;
      @(negedge clock);
      bus.requests_in = '0;
      @(negedge clock);
   endtask

   // Presses one floor and checks lamp -> queue -> req_valid timing (two cycles after the lamp).
   task automatic press_latency(input logic [2:0] f);
      bit seen = 0;
      buttons = 8'd1 << f;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clock);
         if (lamps[f]) seen = 1;
      end
      check("lamp_seen", 32'(seen), 32'd1);
      check("lat_valid_t1", 32'(bus.req_valid), 32'd0);
      @(negedge clock);
      check("lat_valid_t2", 32'(bus.req_valid), 32'd0);
      check("lat_queued", 32'(pending_count), 32'd1);
      @(negedge clock);
      check("lat_valid_t3", 32'(bus.req_valid), 32'd1);
      check("lat_floor", 32'(bus.req_floor), 32'(f));
      buttons = '0;
      cycles(6);
   endtask

   initial begin
      bit seen;
      bus.current_floor = '0;
      bus.requests_in   = '0;
      bus.emergency     = 1'b0;

      // reset state
      @(negedge clock);
      check("rst_req_valid", 32'(bus.req_valid), 32'd0);
      check("rst_req_floor", 32'(bus.req_floor), 32'd0);
      check("rst_lamps", 32'(lamps), 32'd0);
      check("rst_pending", 32'(pending_count), 32'd0);
      reset = 1'b1;
      cycles(2);

      // bouncing button 5: one press only
      buttons = 8'h20; cycles(1);
      buttons = 8'h00; cycles(1);
      buttons = 8'h20; cycles(11);
      buttons = 8'h00; cycles(20);
      check("b5_issue_count", 32'(issued.size()), 32'd1);
      if (issued.size() > 0) check("b5_floor", 32'(issued[0]), 32'd5);
      if (widths.size() > 0) check("b5_width", 32'(widths[0]), 32'd2);
      check("b5_lamps", 32'(lamps), 32'h20);
      check("b5_pending", 32'(pending_count), 32'd0);
      check("b5_floor_retained", 32'(bus.req_floor), 32'd5);
      serve(8'h20);
      check("b5_lamp_cleared", 32'(lamps), 32'd0);

      // simultaneous floors 6, 2, 4
      issued.delete(); widths.delete(); peak = 0;
      buttons = 8'h54; cycles(8);
      buttons = 8'h00; cycles(30);
      check("multi_count", 32'(issued.size()), 32'd3);
      if (issued.size() == 3) begin
         check("multi_first", 32'(issued[0]), 32'd2);
         check("multi_second", 32'(issued[1]), 32'd4);
         check("multi_third", 32'(issued[2]), 32'd6);
      end
      check("multi_peak_ge2", 32'(peak >= 2), 32'd1);
      check("multi_lamps", 32'(lamps), 32'h54);
      foreach (widths[i]) check("multi_width", 32'(widths[i]), 32'd2);
      serve(8'h54);
      check("multi_lamps_cleared", 32'(lamps), 32'd0);

      // floor 3: issue, serve, reissue
      issued.delete(); widths.delete();
      press_latency(3'd3);
      check("f3_lamp", 32'(lamps), 32'h08);
      serve(8'h08);
      check("f3_lamp_cleared", 32'(lamps), 32'd0);
      press_latency(3'd3);
      check("f3_reissue_count", 32'(issued.size()), 32'd2);
      if (widths.size() == 2) check("f3_reissue_width", 32'(widths[1]), 32'd2);
      serve(8'h08);

      // press at current floor is ignored
      issued.delete(); widths.delete();
      bus.current_floor = 3'd4;
      buttons = 8'h10; cycles(8);
      buttons = 8'h00; cycles(10);
      check("cur_lamps", 32'(lamps), 32'd0);
      check("cur_pending", 32'(pending_count), 32'd0);
      check("cur_issue", 32'(issued.size()), 32'd0);
      bus.current_floor = 3'd0;

      // emergency behaviour
      issued.delete(); widths.delete();
`ifdef PANEL_EMERGENCY_FLUSH_EN
      buttons = 8'h8A;
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clock);
         if (pending_count == 4'd2) seen = 1;
      end
      check("flush_queued", 32'(seen), 32'd1);
      bus.emergency = 1'b1;
      @(negedge clock);
      check("flush_pending", 32'(pending_count), 32'd0);
      check("flush_lamps", 32'(lamps), 32'd0);
      buttons = 8'h00; cycles(10);
      check("flush_lamps_held", 32'(lamps), 32'd0);
      bus.emergency = 1'b0; cycles(10);
      check("flush_no_more", 32'(pending_count), 32'd0);
`else
      bus.emergency = 1'b1;
      buttons = 8'h8A; cycles(8);
      buttons = 8'h00; cycles(10);
      check("emer_no_issue", 32'(issued.size()), 32'd0);
      check("emer_pending", 32'(pending_count), 32'd3);
      check("emer_lamps", 32'(lamps), 32'h8A);
      bus.emergency = 1'b0;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clock);
         if (bus.req_valid) seen = 1;
      end
      check("emer_resume", 32'(seen), 32'd1);
      check("emer_resume_floor", 32'(bus.req_floor), 32'd1);
      bus.emergency = 1'b1; cycles(10);
      check("emer_hold_count", 32'(issued.size()), 32'd1);
      if (widths.size() > 0) check("emer_hold_width", 32'(widths[0]), 32'd2);
      check("emer_pending2", 32'(pending_count), 32'd2);
      bus.emergency = 1'b0; cycles(20);
      check("emer_final_count", 32'(issued.size()), 32'd3);
      if (issued.size() == 3) begin
         check("emer_second", 32'(issued[1]), 32'd3);
         check("emer_third", 32'(issued[2]), 32'd7);
      end
      check("emer_drained", 32'(pending_count), 32'd0);
`endif
      serve(8'hFF);
      check("emer_lamps_cleared", 32'(lamps), 32'd0);

      // reset in the middle of HOLD with a floor still queued
      buttons = 8'h06;
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clock);
         if (bus.req_valid) seen = 1;
      end
      check("rst_hold_reached", 32'(seen), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("rst_async_valid", 32'(bus.req_valid), 32'd0);
      check("rst_async_lamps", 32'(lamps), 32'd0);
      check("rst_async_pending", 32'(pending_count), 32'd0);
      buttons = 8'h00;
      @(negedge clock);
      issued.delete(); widths.delete();
      reset = 1'b1;
      @(negedge clock);
      check("post_rst_floor", 32'(bus.req_floor), 32'd0);
      check("post_rst_valid", 32'(bus.req_valid), 32'd0);
      cycles(10);
      check("post_rst_no_issue", 32'(issued.size()), 32'd0);
      check("post_rst_pending", 32'(pending_count), 32'd0);
      check("post_rst_lamps", 32'(lamps), 32'd0);
      check("floor_stable", 32'(unstable), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/floor_request_panel.md
FLOOR_REQUEST_PANEL -- requests

Module: floor_request_panel

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive cycles a button must be stable high to register a press (range 1-15).
REQ-002 Parameter HOLD_CYCLES, default 2, is the number of cycles req_floor/req_valid are held per issued request (range 1-15).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 buttons  input  8  raw car/hall buttons, bit f = floor f, asynchronous to clock and bouncing.
REQ-006 current_floor  input  3  controller's current floor.
REQ-007 requests_in  input  8  controller's pending-request vector.
REQ-008 emergency  input  1  controller emergency condition.
REQ-009 req_floor  output  3  floor number issued to the controller.
REQ-010 req_valid  output  1  high while req_floor carries a newly issued request.
REQ-011 lamps  output  8  button lamps; bit f high = floor f registered and not yet served.
REQ-012 pending_count  output  4  issue-queue occupancy, 0-8.

Function
REQ-013 Each button shall pass through a 2-flop synchronizer, then a per-bit counter; a press event fires once, when the synchronized level has been high for DEBOUNCE_CYCLES consecutive cycles; a new press needs a low level first.
REQ-014 A press of floor f shall be ignored if lamps[f]=1 or f equals current_floor; otherwise lamps[f] sets in the next cycle and bit f sets in a pending-enqueue vector.
REQ-015 Each cycle, the lowest-indexed bit of the pending-enqueue vector shall be cleared and its floor written into an 8-entry FIFO; simultaneous presses enqueue in ascending floor order, one per cycle.
REQ-016 The FIFO cannot overflow, because a floor is queued at most once while its lamp is lit; simultaneous push and pop shall leave pending_count unchanged.
REQ-017 Issue FSM states: IDLE, HOLD.
REQ-018 In IDLE, with the FIFO non-empty and emergency=0, the FSM shall pop the head, drive req_floor=head and req_valid=1 from the next cycle, and enter HOLD.
REQ-019 In HOLD, req_floor and req_valid shall stay stable for exactly HOLD_CYCLES cycles; the FSM then drops req_valid and returns to IDLE, giving a minimum of one idle cycle between issues.
REQ-020 req_floor shall retain its last issued value while req_valid=0.
REQ-021 A repeated issue of the same floor shall still produce a full req_valid pulse.
REQ-022 lamps[f] shall clear on the cycle after a registered 1->0 transition of requests_in[f].
REQ-023 emergency=1 in IDLE shall block popping; emergency rising during HOLD shall not truncate the current HOLD.
REQ-024 Latency from the debounce press event to req_valid rising shall be 3 cycles when the FIFO is empty and the FSM is idle.

Reset
REQ-025 While reset=0, all of the following shall be 0: req_floor, req_valid, lamps, pending_count, the FIFO pointers, the pending-enqueue vector, the synchronizers and the debounce counters; the FSM shall be in IDLE.
REQ-026 Reset asserted mid-HOLD shall drop req_valid immediately (asynchronously) and discard all queued floors.

Configuration
REQ-027 With PANEL_EMERGENCY_FLUSH_EN defined, emergency=1 shall, within one cycle, empty the FIFO, clear the pending-enqueue vector and clear all lamps, and presses shall be ignored while emergency=1.
REQ-028 Without PANEL_EMERGENCY_FLUSH_EN, emergency shall only pause issue (REQ-023); lamps and queue contents shall be preserved and presses accepted.

Verification
REQ-029 buttons[5] bounces 1-0-1 over 3 cycles, then holds high 10 cycles -> exactly one press; lamps=8'h20; req_floor=5 with req_valid high for 2 cycles.
REQ-030 buttons[6], [2] and [4] reach debounce in the same cycle, FIFO idle -> issue order 2, 4, 6; pending_count peaks at 2 or higher; lamps=8'h54.
REQ-031 lamps[3]=1 and requests_in[3] falls 1->0 -> lamps[3]=0 one cycle later; a re-press of floor 3 (current_floor=0) reissues req_floor=3 with a new req_valid pulse.
REQ-032 current_floor=4 and buttons[4] pressed -> no lamp, no issue, pending_count=0.
REQ-033 With the macro defined, 3 queued floors, emergency=1 -> pending_count=0 and lamps=0 next cycle; without the macro -> queue held, issue resumes when emergency=0.
REQ-034 reset driven low during HOLD -> req_valid=0 asynchronously; all outputs 0 after release.
